// File: rtl/tlconv_a2axi_req_pkg.sv
// Shared TileLink / AXI encodings, info-field helpers and FSM state type for
// the TL-A to AXI request converter.
package tlconv_a2axi_req_pkg;

    localparam int TL_BW_OPCODE = 3;
    localparam int TL_BW_PARAM  = 3;

    localparam logic [2:0] TL_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_OP_GET         = 3'd4;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_BW_ID = 4;

    // Info entry layout, MSB first: {opcode, param, size, source}
    localparam int INFO_BW_FIXED = TL_BW_OPCODE + TL_BW_PARAM;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RADDR,
        ST_WADDR,
        ST_WDATA
    } state_t;

    // Transfers wider than 256 beats cannot be expressed as one INCR burst;
    // they saturate at the AXI maximum.
    function automatic logic [7:0] axi_len(input int unsigned size, input int unsigned lg_bytes);
        int unsigned sh;
        if (size <= lg_bytes) return 8'd0;
        sh = size - lg_bytes;
        if (sh >= 32'd8) return 8'hFF;
        return 8'((32'd1 << sh) - 32'd1);
    endfunction

    function automatic logic [2:0] axi_size(input int unsigned size, input int unsigned lg_bytes);
        return (size < lg_bytes) ? 3'(size) : 3'(lg_bytes);
    endfunction

endpackage

// File: rtl/tlconv_a2axi_req_info_fifo.sv
// Small synchronous FIFO carrying per-request TileLink info alongside the
// AXI transaction so the response side can rebuild the D-channel header.
module tlconv_info_fifo #(
    parameter int BW_INFO = 14,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               push,
    input  logic [BW_INFO-1:0] push_data,
    input  logic               pop,
    output logic               valid,
    output logic               full,
    output logic [BW_INFO-1:0] data
);

    localparam int BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW_CNT = $clog2(DEPTH + 1);

    logic [BW_INFO-1:0] mem [DEPTH];
    logic [BW_PTR-1:0]  rd_ptr;
    logic [BW_PTR-1:0]  wr_ptr;
    logic [BW_CNT-1:0]  cnt;
    logic               do_push;
    logic               do_pop;

    function automatic logic [BW_PTR-1:0] next_ptr(input logic [BW_PTR-1:0] p);
        return (p == BW_PTR'(DEPTH - 1)) ? '0 : p + BW_PTR'(1);
    endfunction

    assign valid = (cnt != '0);
    assign full  = (cnt == BW_CNT'(DEPTH));
    assign data  = mem[rd_ptr];

    // A pop frees the slot the simultaneous push needs, even when full.
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + BW_CNT'(1);
                2'b01:   cnt <= cnt - BW_CNT'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tlconv_a2axi_req.sv
// TileLink A-channel to AXI AR/AW/W request converter. One request in flight;
// per-request TL info is queued for the response converter.
//
// state   | meaning
// IDLE    | waiting for a TL-A request; drops unsupported opcodes
// RADDR   | AR presented, waiting for rxarready
// WADDR   | AW presented, first Put beat held upstream
// WDATA   | Put beats passed straight through to W until wlast
module tlconv_a2axi_req
    import tlconv_a2axi_req_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 64,
    parameter int BW_SIZE    = 4,
    parameter int BW_SOURCE  = 4,
    parameter int INFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rstnn,

    input  logic                                sxa_valid,
    input  logic [2:0]                          sxa_opcode,
    input  logic [2:0]                          sxa_param,
    input  logic [BW_SIZE-1:0]                  sxa_size,
    input  logic [BW_SOURCE-1:0]                sxa_source,
    input  logic [BW_ADDR-1:0]                  sxa_address,
    input  logic [BW_DATA/8-1:0]                sxa_mask,
    input  logic [BW_DATA-1:0]                  sxa_data,
    output logic                                sxa_ready,

    output logic                                rxawvalid,
    output logic [AXI_BW_ID-1:0]                rxawid,
    output logic [BW_ADDR-1:0]                  rxawaddr,
    output logic [7:0]                          rxawlen,
    output logic [2:0]                          rxawsize,
    output logic [1:0]                          rxawburst,
    input  logic                                rxawready,

    output logic                                rxwvalid,
    output logic [BW_DATA-1:0]                  rxwdata,
    output logic [BW_DATA/8-1:0]                rxwstrb,
    output logic                                rxwlast,
    input  logic                                rxwready,

    output logic                                rxarvalid,
    output logic [AXI_BW_ID-1:0]                rxarid,
    output logic [BW_ADDR-1:0]                  rxaraddr,
    output logic [7:0]                          rxarlen,
    output logic [2:0]                          rxarsize,
    output logic [1:0]                          rxarburst,
    input  logic                                rxarready,

    output logic                                rinfo_valid,
    output logic [6+BW_SIZE+BW_SOURCE-1:0]      rinfo,
    input  logic                                rinfo_pop,
    output logic                                winfo_valid,
    output logic [6+BW_SIZE+BW_SOURCE-1:0]      winfo,
    input  logic                                winfo_pop,

    output logic                                err_unsupported
);

    localparam int          BW_INFO  = INFO_BW_FIXED + BW_SIZE + BW_SOURCE;
    localparam int unsigned LG_BYTES = $clog2(BW_DATA / 8);

    state_t               state;
    logic                 run;
    logic [2:0]           hdr_opcode;
    logic [2:0]           hdr_param;
    logic [BW_SIZE-1:0]   hdr_size;
    logic [BW_SOURCE-1:0] hdr_source;
    logic [BW_ADDR-1:0]   ax_addr;
    logic [7:0]           ax_len;
    logic [2:0]           ax_size;
    logic                 ar_valid;
    logic                 aw_valid;
    logic                 err_pulse;
    logic [7:0]           beat_cnt;

    logic                 op_get;
    logic                 op_put;
    logic                 op_bad;
    logic                 idle;
    logic                 accept_get;
    logic                 accept_put;
    logic                 accept_bad;
    logic                 ar_fire;
    logic                 aw_fire;
    logic                 w_active;
    logic                 w_fire;
    logic                 w_last;
    logic                 rinfo_full;
    logic                 winfo_full;
    logic [BW_INFO-1:0]   hdr_info;

    always_comb begin
        op_get     = (sxa_opcode == TL_OP_GET);
        op_put     = (sxa_opcode == TL_OP_PUT_FULL) || (sxa_opcode == TL_OP_PUT_PARTIAL);
        op_bad     = !op_get && !op_put;
        idle       = run && (state == ST_IDLE);
        accept_get = idle && sxa_valid && op_get && !rinfo_full;
        accept_put = idle && sxa_valid && op_put && !winfo_full;
        accept_bad = idle && sxa_valid && op_bad;
        ar_fire    = ar_valid && rxarready;
        aw_fire    = aw_valid && rxawready;
        w_active   = (state == ST_WDATA);
        w_fire     = w_active && sxa_valid && rxwready;
        w_last     = (beat_cnt == 8'd0);
        hdr_info   = {hdr_opcode, hdr_param, hdr_size, hdr_source};
    end

    // Puts are never consumed in IDLE: the first beat stays on the bus until
    // WDATA so address and data phases see the same header.
    always_comb begin
        sxa_ready = 1'b0;
        case (state)
            ST_IDLE:  if (run) sxa_ready = op_get ? !rinfo_full : op_bad;
            ST_WDATA: sxa_ready = rxwready;
            default:  sxa_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            hdr_opcode <= '0;
            hdr_param  <= '0;
            hdr_size   <= '0;
            hdr_source <= '0;
            ax_addr    <= '0;
            ax_len     <= '0;
            ax_size    <= '0;
            ar_valid   <= 1'b0;
            aw_valid   <= 1'b0;
            err_pulse  <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            run       <= 1'b1;
            err_pulse <= accept_bad;
            case (state)
                ST_IDLE: begin
                    if (accept_get || accept_put) begin
                        hdr_opcode <= sxa_opcode;
                        hdr_param  <= sxa_param;
                        hdr_size   <= sxa_size;
                        hdr_source <= sxa_source;
                        ax_addr    <= sxa_address;
                        ax_len     <= axi_len(32'(sxa_size), LG_BYTES);
                        ax_size    <= axi_size(32'(sxa_size), LG_BYTES);
                        beat_cnt   <= axi_len(32'(sxa_size), LG_BYTES);
                        if (accept_get) begin
                            state    <= ST_RADDR;
                            ar_valid <= 1'b1;
                        end else begin
                            state    <= ST_WADDR;
                            aw_valid <= 1'b1;
                        end
                    end
                end
                ST_RADDR: begin
                    if (rxarready) begin
                        ar_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_WADDR: begin
                    if (rxawready) begin
                        aw_valid <= 1'b0;
                        state    <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_fire) begin
                        if (w_last) state <= ST_IDLE;
                        else        beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rxarvalid = ar_valid;
    assign rxarid    = '0;
    assign rxaraddr  = ax_addr;
    assign rxarlen   = ax_len;
    assign rxarsize  = ax_size;
    assign rxarburst = AXI_BURST_INCR;

    assign rxawvalid = aw_valid;
    assign rxawid    = '0;
    assign rxawaddr  = ax_addr;
    assign rxawlen   = ax_len;
    assign rxawsize  = ax_size;
    assign rxawburst = AXI_BURST_INCR;

    assign rxwvalid  = w_active && sxa_valid;
    assign rxwdata   = sxa_data;
    assign rxwstrb   = sxa_mask;
    assign rxwlast   = w_active && w_last;

    assign err_unsupported = err_pulse;

    tlconv_info_fifo #(
        .BW_INFO (BW_INFO),
        .DEPTH   (INFO_DEPTH)
    ) u_rinfo (
        .clk       (clk),
        .rstnn     (rstnn),
        .push      (ar_fire),
        .push_data (hdr_info),
        .pop       (rinfo_pop),
        .valid     (rinfo_valid),
        .full      (rinfo_full),
        .data      (rinfo)
    );

    tlconv_info_fifo #(
        .BW_INFO (BW_INFO),
        .DEPTH   (INFO_DEPTH)
    ) u_winfo (
        .clk       (clk),
        .rstnn     (rstnn),
        .push      (aw_fire),
        .push_data (hdr_info),
        .pop       (winfo_pop),
        .valid     (winfo_valid),
        .full      (winfo_full),
        .data      (winfo)
    );

endmodule

// File: tb/tb_tlconv_a2axi_req.sv
// Directed bench for tlconv_a2axi_req with 64-bit data and two-entry info queues.
module tb_tlconv_a2axi_req;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        sxa_valid, sxa_ready;
    logic [2:0]  sxa_opcode, sxa_param;
    logic [3:0]  sxa_size, sxa_source;
    logic [31:0] sxa_address;
    logic [7:0]  sxa_mask;
    logic [63:0] sxa_data;
    logic        rxawvalid, rxawready;
    logic [3:0]  rxawid;
    logic [31:0] rxawaddr;
    logic [7:0]  rxawlen;
    logic [2:0]  rxawsize;
    logic [1:0]  rxawburst;
    logic        rxwvalid, rxwlast, rxwready;
    logic [63:0] rxwdata;
    logic [7:0]  rxwstrb;
    logic        rxarvalid, rxarready;
    logic [3:0]  rxarid;
    logic [31:0] rxaraddr;
    logic [7:0]  rxarlen;
    logic [2:0]  rxarsize;
    logic [1:0]  rxarburst;
    logic        rinfo_valid, rinfo_pop, winfo_valid, winfo_pop;
    logic [13:0] rinfo, winfo;
    logic        err_unsupported;

    int n_vec = 0;
    int n_err = 0;

    tlconv_a2axi_req #(
        .BW_ADDR(32), .BW_DATA(64), .BW_SIZE(4), .BW_SOURCE(4), .INFO_DEPTH(2)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .sxa_valid(sxa_valid), .sxa_opcode(sxa_opcode), .sxa_param(sxa_param),
        .sxa_size(sxa_size), .sxa_source(sxa_source), .sxa_address(sxa_address),
        .sxa_mask(sxa_mask), .sxa_data(sxa_data), .sxa_ready(sxa_ready),
        .rxawvalid(rxawvalid), .rxawid(rxawid), .rxawaddr(rxawaddr), .rxawlen(rxawlen),
        .rxawsize(rxawsize), .rxawburst(rxawburst), .rxawready(rxawready),
        .rxwvalid(rxwvalid), .rxwdata(rxwdata), .rxwstrb(rxwstrb), .rxwlast(rxwlast),
        .rxwready(rxwready),
        .rxarvalid(rxarvalid), .rxarid(rxarid), .rxaraddr(rxaraddr), .rxarlen(rxarlen),
        .rxarsize(rxarsize), .rxarburst(rxarburst), .rxarready(rxarready),
        .rinfo_valid(rinfo_valid), .rinfo(rinfo), .rinfo_pop(rinfo_pop),
        .winfo_valid(winfo_valid), .winfo(winfo), .winfo_pop(winfo_pop),
        .err_unsupported(err_unsupported)
    );

    always #5 clk = ~clk;

    task automatic drive_a(input logic v, input logic [2:0] op, input logic [3:0] size,
                           input logic [3:0] src, input logic [31:0] addr);
        sxa_valid   = v;
        sxa_opcode  = op;
        sxa_param   = 3'd0;
        sxa_size    = size;
        sxa_source  = src;
        sxa_address = addr;
    endtask

    task automatic issue_get(input logic [31:0] addr, input logic [3:0] size, input logic [3:0] src);
        int t;
        @(negedge clk); drive_a(1'b1, 3'd4, size, src, addr); #1;
        t = 0;
        while (sxa_ready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        n_vec++;
        if (t >= 20) begin n_err++; $display("FAIL issue_get_accept: sxa_ready=%b want 1", sxa_ready); end
        @(negedge clk); sxa_valid = 1'b0; rxarready = 1'b1; #1;
        n_vec++;
        if ({rxarvalid, rxaraddr} !== {1'b1, addr}) begin
            n_err++; $display("FAIL issue_get_ar: got %b/%h want 1/%h", rxarvalid, rxaraddr, addr);
        end
        @(negedge clk); rxarready = 1'b0;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        drive_a(1'b1, 3'd6, 4'd0, 4'd0, 32'h0);
        sxa_mask = 8'h00; sxa_data = '0;
        rxawready = 0; rxwready = 0; rxarready = 0; rinfo_pop = 0; winfo_pop = 0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({rxarvalid, rxawvalid, rxwvalid, err_unsupported, sxa_ready, rinfo_valid, winfo_valid} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ar/aw/w/err/rdy/ri/wi=%b%b%b%b%b%b%b want 0000000",
                     rxarvalid, rxawvalid, rxwvalid, err_unsupported, sxa_ready, rinfo_valid, winfo_valid);
        end
        @(negedge clk); drive_a(1'b1, 3'd4, 4'd3, 4'd1, 32'h40); #1;
        n_vec++;
        if (sxa_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_get: got %b want 0", sxa_ready); end
        @(negedge clk); rstnn = 1'b1; sxa_valid = 1'b0;
    endtask

    task automatic test_get();
        @(negedge clk); drive_a(1'b1, 3'd4, 4'd3, 4'd5, 32'h100); #1;
        n_vec++;
        if (sxa_ready !== 1'b1) begin n_err++; $display("FAIL get_accept: sxa_ready=%b want 1", sxa_ready); end
        @(negedge clk); sxa_valid = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarid} !== {1'b1, 32'h100, 8'd0, 3'd3, 2'b01, 4'd0}) begin
            n_err++;
            $display("FAIL get_ar_fields: v=%b addr=%h len=%0d size=%0d burst=%b id=%0d want 1/100/0/3/01/0",
                     rxarvalid, rxaraddr, rxarlen, rxarsize, rxarburst, rxarid);
        end
        n_vec++;
        if ({sxa_ready, rinfo_valid} !== 2'b00) begin
            n_err++; $display("FAIL get_raddr_ready: rdy/ri=%b%b want 00", sxa_ready, rinfo_valid);
        end
        rxarready = 1'b1;
        @(negedge clk); rxarready = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, rinfo_valid, rinfo} !== {1'b0, 1'b1, 3'd4, 3'd0, 4'd3, 4'd5}) begin
            n_err++; $display("FAIL get_rinfo: arv=%b riv=%b rinfo=%h want 0/1/%h",
                              rxarvalid, rinfo_valid, rinfo, {3'd4, 3'd0, 4'd3, 4'd5});
        end
        rinfo_pop = 1'b1;
        @(negedge clk); rinfo_pop = 1'b0; #1;
        n_vec++;
        if (rinfo_valid !== 1'b0) begin n_err++; $display("FAIL get_pop: rinfo_valid=%b want 0", rinfo_valid); end
    endtask

    task automatic test_put_full();
        logic [63:0] d;
        @(negedge clk); drive_a(1'b1, 3'd0, 4'd5, 4'd2, 32'h200); sxa_mask = 8'hFF; sxa_data = 64'hA0; #1;
        n_vec++;
        if (sxa_ready !== 1'b0) begin n_err++; $display("FAIL put_idle_ready: got %b want 0", sxa_ready); end
        @(negedge clk); #1;
        n_vec++;
        if ({rxawvalid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawid} !== {1'b1, 32'h200, 8'd3, 3'd3, 2'b01, 4'd0}) begin
            n_err++;
            $display("FAIL put_aw_fields: v=%b addr=%h len=%0d size=%0d burst=%b id=%0d want 1/200/3/3/01/0",
                     rxawvalid, rxawaddr, rxawlen, rxawsize, rxawburst, rxawid);
        end
        n_vec++;
        if ({sxa_ready, rxwvalid, winfo_valid} !== 3'b000) begin
            n_err++; $display("FAIL put_waddr_hold: rdy/wv/wi=%b%b%b want 000", sxa_ready, rxwvalid, winfo_valid);
        end
        rxawready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin rxawready = 1'b0; rxwready = 1'b1; end
            d = 64'hD0D0_0000_0000_0000 + 64'(i);
            sxa_data = d; #1;
            n_vec++;
            if ({rxwvalid, sxa_ready, rxwlast, rxwdata, rxwstrb} !== {1'b1, 1'b1, (i == 3), d, 8'hFF}) begin
                n_err++; $display("FAIL put_beat%0d: v=%b rdy=%b last=%b data=%h strb=%h want 1/1/%b/%h/ff",
                                  i, rxwvalid, sxa_ready, rxwlast, rxwdata, rxwstrb, (i == 3), d);
            end
            if (i == 0) begin
                n_vec++;
                if ({rxawvalid, winfo_valid, winfo} !== {1'b0, 1'b1, 3'd0, 3'd0, 4'd5, 4'd2}) begin
                    n_err++; $display("FAIL put_winfo: awv=%b wiv=%b winfo=%h want 0/1/%h",
                                      rxawvalid, winfo_valid, winfo, {3'd0, 3'd0, 4'd5, 4'd2});
                end
            end
        end
        // An unsupported opcode is taken only in IDLE, proving the burst ended.
        @(negedge clk); drive_a(1'b1, 3'd6, 4'd0, 4'd0, 32'h0); rxwready = 1'b0; #1;
        n_vec++;
        if ({rxwvalid, sxa_ready} !== 2'b01) begin
            n_err++; $display("FAIL put_back_idle: wv/rdy=%b%b want 01", rxwvalid, sxa_ready);
        end
        @(negedge clk); sxa_valid = 1'b0; winfo_pop = 1'b1;
        @(negedge clk); winfo_pop = 1'b0;
    endtask

    task automatic test_put_partial();
        @(negedge clk); drive_a(1'b1, 3'd1, 4'd2, 4'd3, 32'h304); sxa_param = 3'd2;
        sxa_mask = 8'h0F; sxa_data = 64'h1122_3344_5566_7788;
        @(negedge clk); #1;
        n_vec++;
        if ({rxawvalid, rxawaddr, rxawlen, rxawsize} !== {1'b1, 32'h304, 8'd0, 3'd2}) begin
            n_err++; $display("FAIL partial_aw: v=%b addr=%h len=%0d size=%0d want 1/304/0/2",
                              rxawvalid, rxawaddr, rxawlen, rxawsize);
        end
        rxawready = 1'b1;
        @(negedge clk); rxawready = 1'b0; rxwready = 1'b1; #1;
        n_vec++;
        if ({rxwvalid, rxwlast, rxwstrb, winfo} !== {1'b1, 1'b1, 8'h0F, 3'd1, 3'd2, 4'd2, 4'd3}) begin
            n_err++; $display("FAIL partial_w: v=%b last=%b strb=%h winfo=%h want 1/1/0f/%h",
                              rxwvalid, rxwlast, rxwstrb, winfo, {3'd1, 3'd2, 4'd2, 4'd3});
        end
        @(negedge clk); sxa_valid = 1'b0; rxwready = 1'b0; winfo_pop = 1'b1;
        @(negedge clk); winfo_pop = 1'b0; #1;
        n_vec++;
        if ({rxwvalid, winfo_valid} !== 2'b00) begin
            n_err++; $display("FAIL partial_done: wv/wi=%b%b want 00", rxwvalid, winfo_valid);
        end
    endtask

    task automatic test_ar_backpressure();
        @(negedge clk); drive_a(1'b1, 3'd4, 4'd2, 4'd7, 32'h340); #1;
        n_vec++;
        if (sxa_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept: sxa_ready=%b want 1", sxa_ready); end
        @(negedge clk); drive_a(1'b1, 3'd4, 4'd3, 4'd8, 32'h400);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_vec++;
            if ({rxarvalid, rxaraddr, rxarlen, rxarsize, sxa_ready} !== {1'b1, 32'h340, 8'd0, 3'd2, 1'b0}) begin
                n_err++; $display("FAIL bp_hold%0d: v=%b addr=%h len=%0d size=%0d rdy=%b want 1/340/0/2/0",
                                  k, rxarvalid, rxaraddr, rxarlen, rxarsize, sxa_ready);
            end
        end
        rxarready = 1'b1;
        @(negedge clk); rxarready = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, sxa_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_next_accept: arv/rdy=%b%b want 01", rxarvalid, sxa_ready);
        end
        @(negedge clk); sxa_valid = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, rxaraddr, rxarsize} !== {1'b1, 32'h400, 3'd3}) begin
            n_err++; $display("FAIL bp_second_ar: v=%b addr=%h size=%0d want 1/400/3", rxarvalid, rxaraddr, rxarsize);
        end
        rxarready = 1'b1;
        @(negedge clk); rxarready = 1'b0; #1;
        n_vec++;
        if (rinfo !== {3'd4, 3'd0, 4'd2, 4'd7}) begin
            n_err++; $display("FAIL bp_rinfo0: got %h want %h", rinfo, {3'd4, 3'd0, 4'd2, 4'd7});
        end
        rinfo_pop = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if ({rinfo_valid, rinfo} !== {1'b1, 3'd4, 3'd0, 4'd3, 4'd8}) begin
            n_err++; $display("FAIL bp_rinfo1: v=%b info=%h want 1/%h", rinfo_valid, rinfo, {3'd4, 3'd0, 4'd3, 4'd8});
        end
        @(negedge clk); rinfo_pop = 1'b0; #1;
        n_vec++;
        if (rinfo_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: rinfo_valid=%b want 0", rinfo_valid); end
    endtask

    task automatic test_queue_full();
        issue_get(32'h1000, 4'd3, 4'd1);
        issue_get(32'h1040, 4'd3, 4'd2);
        @(negedge clk); drive_a(1'b1, 3'd4, 4'd3, 4'd3, 32'h1080); #1;
        n_vec++;
        if (sxa_ready !== 1'b0) begin n_err++; $display("FAIL full_block: sxa_ready=%b want 0", sxa_ready); end
        @(negedge clk); #1;
        n_vec++;
        if ({rxarvalid, sxa_ready} !== 2'b00) begin
            n_err++; $display("FAIL full_still_blocked: arv/rdy=%b%b want 00", rxarvalid, sxa_ready);
        end
        rinfo_pop = 1'b1;
        @(negedge clk); rinfo_pop = 1'b0; #1;
        n_vec++;
        if (sxa_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop: sxa_ready=%b want 1", sxa_ready); end
        @(negedge clk); sxa_valid = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, rxaraddr} !== {1'b1, 32'h1080}) begin
            n_err++; $display("FAIL full_third_ar: v=%b addr=%h want 1/1080", rxarvalid, rxaraddr);
        end
        rxarready = 1'b1;
        @(negedge clk); rxarready = 1'b0; #1;
        n_vec++;
        if ({rinfo_valid, rinfo} !== {1'b1, 3'd4, 3'd0, 4'd3, 4'd2}) begin
            n_err++; $display("FAIL full_order: v=%b info=%h want 1/%h", rinfo_valid, rinfo, {3'd4, 3'd0, 4'd3, 4'd2});
        end
        rinfo_pop = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if (rinfo !== {3'd4, 3'd0, 4'd3, 4'd3}) begin
            n_err++; $display("FAIL full_order2: info=%h want %h", rinfo, {3'd4, 3'd0, 4'd3, 4'd3});
        end
        @(negedge clk); rinfo_pop = 1'b0;
    endtask

    task automatic test_unsupported();
        @(negedge clk); drive_a(1'b1, 3'd6, 4'd3, 4'd9, 32'h700); #1;
        n_vec++;
        if ({sxa_ready, err_unsupported} !== 2'b10) begin
            n_err++; $display("FAIL unsup_accept: rdy/err=%b%b want 10", sxa_ready, err_unsupported);
        end
        @(negedge clk); sxa_valid = 1'b0; #1;
        n_vec++;
        if ({err_unsupported, rxarvalid, rxawvalid, rxwvalid} !== 4'b1000) begin
            n_err++; $display("FAIL unsup_pulse: err/ar/aw/w=%b%b%b%b want 1000",
                              err_unsupported, rxarvalid, rxawvalid, rxwvalid);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({err_unsupported, rxarvalid, rxawvalid, rxwvalid, rinfo_valid, winfo_valid} !== 6'b0) begin
            n_err++; $display("FAIL unsup_once: err/ar/aw/w/ri/wi=%b%b%b%b%b%b want 000000",
                              err_unsupported, rxarvalid, rxawvalid, rxwvalid, rinfo_valid, winfo_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk); drive_a(1'b1, 3'd0, 4'd5, 4'd4, 32'h500); sxa_mask = 8'hFF; sxa_data = 64'h55;
        @(negedge clk); rxawready = 1'b1;
        @(negedge clk); rxawready = 1'b0; rxwready = 1'b1;
        @(negedge clk);
        @(negedge clk); rstnn = 1'b0; #1;
        n_vec++;
        if ({rxarvalid, rxawvalid, rxwvalid, rxwlast, err_unsupported, sxa_ready, rinfo_valid, winfo_valid} !== 8'b0) begin
            n_err++; $display("FAIL rst_mid: ar/aw/w/last/err/rdy/ri/wi=%b%b%b%b%b%b%b%b want 00000000",
                              rxarvalid, rxawvalid, rxwvalid, rxwlast, err_unsupported, sxa_ready, rinfo_valid, winfo_valid);
        end
        @(negedge clk); @(negedge clk); rstnn = 1'b1; sxa_valid = 1'b0; rxwready = 1'b0;
        @(negedge clk); sxa_valid = 1'b1; rxwready = 1'b1; #1;
        n_vec++;
        if (rxwvalid !== 1'b0) begin n_err++; $display("FAIL rst_no_beats: rxwvalid=%b want 0", rxwvalid); end
        sxa_valid = 1'b0; rxwready = 1'b0;
        issue_get(32'h600, 4'd3, 4'd1);
        #1;
        n_vec++;
        if ({rinfo_valid, rinfo, winfo_valid} !== {1'b1, 3'd4, 3'd0, 4'd3, 4'd1, 1'b0}) begin
            n_err++; $display("FAIL rst_then_get: riv=%b rinfo=%h wiv=%b want 1/%h/0",
                              rinfo_valid, rinfo, winfo_valid, {3'd4, 3'd0, 4'd3, 4'd1});
        end
        rinfo_pop = 1'b1;
        @(negedge clk); rinfo_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_get();
        test_put_full();
        test_put_partial();
        test_ar_backpressure();
        test_queue_full();
        test_unsupported();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlconv_a2axi_req.md
TLCONV_A2AXI_REQ -- requirements
Module: tlconv_a2axi_req

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- BW_ADDR, 32, address width.
- BW_DATA, 64, data width; must be a power of 2 and at least 32.
- BW_SIZE, 4, TL size width.
- BW_SOURCE, 4, TL source width.
- INFO_DEPTH, 4, depth of each info queue.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, the single clock.
- rstnn, in, 1, asynchronous active-low reset.
REQ-003 TL A-channel inputs SHALL be:
- sxa_valid, in, 1.
- sxa_opcode, in, 3.
- sxa_param, in, 3.
- sxa_size, in, BW_SIZE.
- sxa_source, in, BW_SOURCE.
- sxa_address, in, BW_ADDR.
- sxa_mask, in, BW_DATA/8.
- sxa_data, in, BW_DATA.
- sxa_ready, out, 1.
REQ-004 AXI AW outputs SHALL be rxawvalid/awid/awaddr/awlen(8)/awsize(3)/awburst(2); rxawready is an input.
REQ-005 AXI W outputs SHALL be rxwvalid/wdata/wstrb/wlast; rxwready is an input.
REQ-006 AXI AR outputs SHALL be rxarvalid/arid/araddr/arlen/arsize/arburst; rxarready is an input.
REQ-007 Read info queue SHALL be rinfo_valid (out, 1), rinfo (out, 6+BW_SIZE+BW_SOURCE, {opcode,param,size,source}), rinfo_pop (in, 1); the write info queue (winfo_*) SHALL be identical.
REQ-008 err_unsupported (out, 1) SHALL be a one-cycle pulse per dropped request.

Function
REQ-009 Supported opcodes SHALL be Get=4, PutFullData=0, PutPartialData=1; every other opcode is accepted (sxa_ready=1 in IDLE), produces no AXI traffic, and pulses err_unsupported.
REQ-010 The FSM SHALL have states IDLE, RADDR, WADDR, WDATA.
REQ-011 In IDLE, a Get SHALL be accepted only when the read queue is not full: header latched, transition to RADDR; rxarvalid rises the next cycle.
REQ-012 In RADDR, rxarvalid SHALL stay high with stable fields until rxarready; on that handshake, push the read info and return to IDLE.
REQ-013 In IDLE, a Put with a non-full write queue SHALL latch the header without consuming the beat (sxa_ready=0) and transition to WADDR.
REQ-014 In WADDR, on the rxawready handshake, the block SHALL push the write info and transition to WDATA.
REQ-015 In WDATA, the block SHALL drive rxwvalid=sxa_valid, sxa_ready=rxwready, wdata=sxa_data, wstrb=sxa_mask; wlast is asserted on beat beats-1; after the wlast handshake, return to IDLE.
REQ-016 Beat count SHALL be beats = 2^(size-log2(BW_DATA/8)) when size exceeds log2(BW_DATA/8), else 1.
REQ-017 AXI length and size SHALL be len=beats-1 and axsize=min(size, log2(BW_DATA/8)).
REQ-018 AXI burst, ID and address SHALL be burst=INCR, id=0 (responses return in order), and addr=sxa_address.
REQ-019 Each info queue SHALL be a FIFO: push and pop in the same cycle are both honoured when non-empty; full blocks acceptance only, not an in-flight request; pop while empty is ignored.
REQ-020 sxa_ready SHALL be 0 in RADDR and WADDR.

Reset
REQ-021 While rstnn=0, all valid outputs, err_unsupported and sxa_ready SHALL be 0, the FSM SHALL be IDLE, and both queues SHALL be empty.
REQ-022 Reset mid-burst SHALL abandon the burst with no further W beats; upstream and downstream reset together.

Structure
REQ-023 TL opcode codes, AXI burst/response encodings, and the info-field layout SHALL live in the shared TileLink/AXI define headers.
REQ-024 The two info queues SHALL be instances of one sub-module, tlconv_info_fifo (params BW_INFO, DEPTH).

Verification (BW_DATA=64)
REQ-025 Get, size 3, addr 0x100, source 5 -> next cycle: araddr 0x100, arlen 0, arsize 3, arburst INCR, arid 0; after arready, rinfo_valid=1 with opcode 4 and source 5.
REQ-026 PutFull, size 5, addr 0x200 -> awlen 3, awsize 3; 4 W beats with wlast only on beat 4; winfo carries opcode 0.
REQ-027 rxarready held 0 for 5 cycles -> rxarvalid stays 1 with stable fields and sxa_ready stays 0; the next Get is accepted only after the handshake.
REQ-028 INFO_DEPTH=2, three Gets with no pops -> third not accepted; a single rinfo_pop -> third accepted next cycle.
REQ-029 Opcode 6 -> consumed in one cycle, err_unsupported pulses once, and no AXI valid rises.
REQ-030 rstnn dropped after beat 2 of a 4-beat Put -> all outputs 0 and queues empty; a new Get after reset completes normally.
